// File: rtl/add_seq_pkg.sv
// rtl/add_seq_pkg.sv - shared state type and default sizes for the sequential limb adder
package add_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int ADD_SEQ_DW = 18;
  localparam int ADD_SEQ_NW = 4;

endpackage

// File: rtl/limb_add.sv
// rtl/limb_add.sv - one DW-bit limb adder with carry-out and carry into the MSB
module limb_add #(
  parameter int DW = 18
) (
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  logic          ci_i,
  output logic [DW-1:0] s_o,
  output logic          co_o,
  output logic          msb_ci_o
);

  logic [DW:0] full;

  assign full = {1'b0, a_i} + {1'b0, b_i} + {{DW{1'b0}}, ci_i};
  assign s_o  = full[DW-1:0];
  assign co_o = full[DW];
  // The MSB sum bit is a^b^cin at that position, so its carry-in falls out without a second adder
  assign msb_ci_o = full[DW-1] ^ a_i[DW-1] ^ b_i[DW-1];

endmodule

// File: rtl/add_seq_ctrl.sv
// rtl/add_seq_ctrl.sv - multi-limb adder, one limb per cycle; optional ovf port via ADD_SEQ_OVF_EN
module add_seq_ctrl
  import add_seq_pkg::*;
#(
  parameter int DW = ADD_SEQ_DW,
  parameter int NW = ADD_SEQ_NW,
  parameter int US = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW*NW-1:0] a,
  input  logic [DW*NW-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW*NW-1:0] sum,
  output logic             carry,
  output logic             busy
`ifdef ADD_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int W  = DW * NW;
  localparam int CW = $clog2(NW) + 1;
  localparam logic [CW-1:0] K_LAST = CW'(NW - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   k_q, k_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            cr_q, cr_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            carry_q, carry_d;
`ifdef ADD_SEQ_OVF_EN
  logic            ovf_q, ovf_d;
`endif

  logic [DW-1:0]   limb_a, limb_b, limb_s;
  logic            limb_co, limb_msb_ci;
  logic            top_carry;

  assign limb_a = a_q[int'(k_q)*DW +: DW];
  assign limb_b = b_q[int'(k_q)*DW +: DW];

  limb_add #(
    .DW(DW)
  ) u_limb_add (
    .a_i     (limb_a),
    .b_i     (limb_b),
    .ci_i    (cr_q),
    .s_o     (limb_s),
    .co_o    (limb_co),
    .msb_ci_o(limb_msb_ci)
  );

  // Signed carry is bit W of the sign-extended sum: a^b^co at the top, with a^b recovered from s^msb_ci
  assign top_carry = (US != 0) ? limb_co : (limb_s[DW-1] ^ limb_msb_ci ^ limb_co);

  // Next-state: capture operands in IDLE, walk limbs in RUN, hold result in DONE until taken
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    cr_d    = cr_q;
    sum_d   = sum_q;
    carry_d = carry_q;
`ifdef ADD_SEQ_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          cr_d    = c_in;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[int'(k_q)*DW +: DW] = limb_s;
        cr_d = limb_co;
        if (k_q == K_LAST) begin
          state_d = DONE;
          carry_d = top_carry;
`ifdef ADD_SEQ_OVF_EN
          ovf_d   = (US != 0) ? limb_co : (limb_msb_ci ^ limb_co);
`endif
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any operation and clears the visible result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cr_q    <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
`ifdef ADD_SEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cr_q    <= cr_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
`ifdef ADD_SEQ_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign carry     = carry_q;
`ifdef ADD_SEQ_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_add_seq_ctrl.sv
// tb/tb_add_seq_ctrl.sv - randomized bench with behavioural model for add_seq_ctrl
module tb_add_seq_ctrl;

  localparam int W = 72;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, out_ready, c_in;
  logic [W-1:0] a, b;

  logic u_in_ready, u_out_valid, u_carry, u_busy;
  logic s_in_ready, s_out_valid, s_carry, s_busy;
  logic [W-1:0] u_sum, s_sum;

  logic n_in_valid, n_out_ready, n_c_in;
  logic [17:0] n_a, n_b, n_sum;
  logic n_in_ready, n_out_valid, n_carry, n_busy;

  logic u_ovf_w, s_ovf_w, n_ovf_w;
`ifdef ADD_SEQ_OVF_EN
  logic u_ovf, s_ovf, n_ovf;
  assign u_ovf_w = u_ovf;
  assign s_ovf_w = s_ovf;
  assign n_ovf_w = n_ovf;
`else
  assign u_ovf_w = 1'b0;
  assign s_ovf_w = 1'b0;
  assign n_ovf_w = 1'b0;
`endif

  always #5 clk = ~clk;

  add_seq_ctrl #(.DW(18), .NW(4), .US(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(u_in_ready),
    .a(a), .b(b), .c_in(c_in), .out_valid(u_out_valid), .out_ready(out_ready),
    .sum(u_sum), .carry(u_carry), .busy(u_busy)
`ifdef ADD_SEQ_OVF_EN
    , .ovf(u_ovf)
`endif
  );

  add_seq_ctrl #(.DW(18), .NW(4), .US(0)) s_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .a(a), .b(b), .c_in(c_in), .out_valid(s_out_valid), .out_ready(out_ready),
    .sum(s_sum), .carry(s_carry), .busy(s_busy)
`ifdef ADD_SEQ_OVF_EN
    , .ovf(s_ovf)
`endif
  );

  add_seq_ctrl #(.DW(18), .NW(1), .US(1)) n_dut (
    .clk(clk), .rst(rst), .in_valid(n_in_valid), .in_ready(n_in_ready),
    .a(n_a), .b(n_b), .c_in(n_c_in), .out_valid(n_out_valid), .out_ready(n_out_ready),
    .sum(n_sum), .carry(n_carry), .busy(n_busy)
`ifdef ADD_SEQ_OVF_EN
    , .ovf(n_ovf)
`endif
  );

  int checks = 0;
  int passes = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
  endtask

  // Reference: the result is just the widened sum of the operands, zero- or sign-extended
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci, input bit us);
    if (us) return {1'b0, x} + {1'b0, y} + (W+1)'(ci);
    return {x[W-1], x} + {y[W-1], y} + (W+1)'(ci);
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic [W:0] full, input bit us);
    if (us) return full[W];
    return (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
  endfunction

  function automatic logic [W-1:0] rnd72();
    if ($urandom_range(0, 7) == 0) return '1;
    return {8'($urandom), $urandom, $urandom};
  endfunction

  // Transaction-level model of the two NW=4 instances: idle / counting down NW cycles / done
  bit m_idle = 1, m_done = 0;
  int m_left = 0;
  logic [W:0] m_full[2];
  logic m_ovf[2];

  always @(posedge clk) begin
    if (rst) begin
      m_idle = 1; m_done = 0; m_left = 0;
      for (int i = 0; i < 2; i++) begin m_full[i] = '0; m_ovf[i] = 1'b0; end
    end else if (m_idle) begin
      if (in_valid) begin
        m_idle = 0; m_left = 4;
        for (int i = 0; i < 2; i++) begin
          m_full[i] = ref_add(a, b, c_in, (i == 0));
          m_ovf[i]  = ref_ovf(a, b, m_full[i], (i == 0));
        end
      end
    end else if (!m_done) begin
      m_left--;
      if (m_left == 0) m_done = 1;
    end else if (out_ready) begin
      m_done = 0; m_idle = 1;
    end
  end

  task automatic cmp_inst(input int i, input logic rdy, input logic vld, input logic bsy,
                          input logic [W-1:0] sm, input logic cy, input logic ov);
    string p;
    p = (i == 0) ? "u_" : "s_";
    chk({p, "in_ready"}, rdy, m_idle);
    chk({p, "out_valid"}, vld, m_done);
    chk({p, "busy"}, bsy, !m_idle);
    if (m_idle || m_done) begin
      chk({p, "sum"}, sm, m_full[i][W-1:0]);
      chk({p, "carry"}, cy, m_full[i][W]);
    end
`ifdef ADD_SEQ_OVF_EN
    if (m_done) chk({p, "ovf"}, ov, m_ovf[i]);
`endif
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_inst(0, u_in_ready, u_out_valid, u_busy, u_sum, u_carry, u_ovf_w);
      cmp_inst(1, s_in_ready, s_out_valid, s_busy, s_sum, s_carry, s_ovf_w);
    end
  end

  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                          output int lat);
    a = av; b = bv; c_in = cv; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; lat = 0;
    while (!u_out_valid && lat < 32) begin
      in_valid = 1'($urandom_range(0, 1));
      a = rnd72(); b = rnd72(); c_in = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      lat++;
    end
    out_ready = 1'b0;
  endtask

  task automatic finish_op(input int hold);
    repeat (hold) begin
      in_valid = 1'($urandom_range(0, 1));
      a = rnd72(); b = rnd72();
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
  endtask

  task automatic n_op(input logic [17:0] av, input logic [17:0] bv, input logic cv);
    int lat;
    logic [18:0] e;
    e = {1'b0, av} + {1'b0, bv} + 19'(cv);
    n_a = av; n_b = bv; n_c_in = cv; n_in_valid = 1'b1;
    @(posedge clk); #1;
    n_in_valid = 1'b0; lat = 0;
    chk("n_busy_run", n_busy, 1'b1);
    while (!n_out_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("n_latency", lat, 1);
    chk("n_sum", n_sum, e[17:0]);
    chk("n_carry", n_carry, e[18]);
`ifdef ADD_SEQ_OVF_EN
    chk("n_ovf", n_ovf_w, e[18]);
`endif
    n_out_ready = 1'b1;
    @(posedge clk); #1;
    n_out_ready = 1'b0;
    chk("n_in_ready_after", n_in_ready, 1'b1);
    chk("n_sum_held", n_sum, e[17:0]);
  endtask

  initial begin
    int lat;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; c_in = 1'b0; a = '0; b = '0;
    n_in_valid = 1'b0; n_out_ready = 1'b0; n_c_in = 1'b0; n_a = '0; n_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1;
    rst = 1'b0;

    chk("rst_in_ready", u_in_ready, 1'b1);
    chk("rst_out_valid", u_out_valid, 1'b0);
    chk("rst_busy", s_busy, 1'b0);
    chk("rst_sum", u_sum, 72'h0);
    chk("rst_carry", s_carry, 1'b0);
    chk("rst_n_sum", n_sum, 18'h0);
`ifdef ADD_SEQ_OVF_EN
    chk("rst_ovf", u_ovf_w, 1'b0);
`endif

    // all-ones + 0 + carry-in wraps to zero
    start_op(72'hFF_FFFF_FFFF_FFFF_FFFF, 72'h0, 1'b1, lat);
    chk("lat_wrap", lat, 4);
    chk("u_sum_wrap", u_sum, 72'h0);
    chk("u_carry_wrap", u_carry, 1'b1);
    chk("s_sum_wrap", s_sum, 72'h0);
    chk("s_carry_wrap", s_carry, 1'b0);
    finish_op(0);

    // -1 + -1, with the result held 5 cycles while in_valid pulses
    start_op(72'hFF_FFFF_FFFF_FFFF_FFFF, 72'hFF_FFFF_FFFF_FFFF_FFFF, 1'b0, lat);
    chk("lat_neg", lat, 4);
    chk("s_sum_neg", s_sum, 72'hFF_FFFF_FFFF_FFFF_FFFE);
    chk("s_carry_neg", s_carry, 1'b1);
    chk("u_sum_neg", u_sum, 72'hFF_FFFF_FFFF_FFFF_FFFE);
`ifdef ADD_SEQ_OVF_EN
    chk("s_ovf_neg", s_ovf_w, 1'b0);
    chk("u_ovf_neg", u_ovf_w, 1'b1);
`endif
    finish_op(5);
    chk("in_ready_after_hold", u_in_ready, 1'b1);

    // max positive + 1 overflows in signed mode only
    start_op(72'h7F_FFFF_FFFF_FFFF_FFFF, 72'h1, 1'b0, lat);
    chk("s_sum_max", s_sum, 72'h80_0000_0000_0000_0000);
    chk("s_carry_max", s_carry, 1'b0);
    chk("u_carry_max", u_carry, 1'b0);
`ifdef ADD_SEQ_OVF_EN
    chk("s_ovf_max", s_ovf_w, 1'b1);
    chk("u_ovf_max", u_ovf_w, 1'b0);
`endif
    finish_op(1);

    // reset in the second RUN cycle aborts the operation
    a = 72'h12_3456_789A_BCDE_F012; b = 72'h0F_0F0F_0F0F_0F0F_0F0F; c_in = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_in_ready", u_in_ready, 1'b1);
    chk("abort_out_valid", s_out_valid, 1'b0);
    chk("abort_sum", u_sum, 72'h0);
    start_op(72'h00_0000_0000_0003_FFFF, 72'h00_0000_0000_0000_0001, 1'b0, lat);
    chk("lat_after_abort", lat, 4);
    chk("u_sum_after_abort", u_sum, 72'h00_0000_0000_0004_0000);
    finish_op(2);

    // randomized operations against the model
    for (int i = 0; i < 40; i++) begin
      start_op(rnd72(), rnd72(), 1'($urandom_range(0, 1)), lat);
      chk("lat_rand", lat, 4);
      finish_op(int'($urandom_range(0, 4)));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    // single-limb instance
    n_op(18'h3FFFF, 18'h1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      n_op(18'($urandom), 18'($urandom), 1'($urandom_range(0, 1)));
    end

    chk_en = 0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/add_seq_ctrl.md
ADD_SEQ_CTRL -- requirements
Module: add_seq_ctrl

Interface
REQ-001 Parameter DW, default 18: limb width in bits.
REQ-002 Parameter NW, default 4: number of limbs per operand; legal range 1..64.
REQ-003 Parameter US, default 1: 1 = unsigned operation, 0 = two's-complement signed operation.
REQ-004 clk  input  1: single clock; all state changes on its rising edge.
REQ-005 rst  input  1: reset, synchronous and active-high.
REQ-006 in_valid  input  1: operand set present.
REQ-007 in_ready  output  1: block can accept an operand set.
REQ-008 a, b  input  DW*NW each: operands, limb 0 = bits DW-1:0.
REQ-009 c_in  input  1: carry-in, always weighted +1 or 0 in both modes.
REQ-010 out_valid  output  1: result present.
REQ-011 out_ready  input  1: consumer accepts result.
REQ-012 sum  output  DW*NW: result.
REQ-013 carry  output  1: bit DW*NW of the (US ? zero-extended : sign-extended) full-width sum.
REQ-014 busy  output  1: high in RUN or DONE.

Function
REQ-015 FSM states SHALL be IDLE, RUN, DONE.
REQ-016 in_ready SHALL equal (state==IDLE); inputs are ignored otherwise.
REQ-017 IDLE: in_valid&&in_ready at edge T SHALL register a, b and c_in, clear limb counter to 0, and enter RUN.
REQ-018 RUN: each cycle SHALL add limb[k] of a and b plus the carry register through one DW-bit adder, write sum limb k, update the carry register, and increment k.
REQ-019 When k==NW-1 the RUN cycle SHALL enter DONE; out_valid SHALL first be high exactly NW cycles after edge T.
REQ-020 For the top limb with US=0, carry SHALL be a[MSB]^b[MSB]^(limb carry-out); otherwise carry SHALL be the limb carry-out.
REQ-021 DONE: out_valid=1; sum and carry SHALL stay stable until out_valid&&out_ready, then return to IDLE.
REQ-022 No overlap: the next operand set is accepted at the earliest one cycle after the result handshake (throughput one op per NW+2 cycles).
REQ-023 NW=1 SHALL work: RUN lasts one cycle.
REQ-024 Limb counter SHALL be $clog2(NW)+1 bits wide, with no wrap beyond NW-1.
REQ-025 sum and carry SHALL be undefined-free: they hold the last result in IDLE.

Reset
REQ-026 rst SHALL force IDLE, in_ready=1 (after reset release), out_valid=0, busy=0, sum=0, carry=0, counter=0, carry register=0.
REQ-027 rst during RUN or DONE SHALL abort the operation with no output handshake; rst has priority over all other events.

Configuration
REQ-028 Macro ADD_SEQ_OVF_EN: when defined, an output port ovf (1 bit, reset 0) SHALL exist, valid with out_valid: US=1 -> ovf=carry; US=0 -> ovf = carry into top-limb MSB XOR carry out of top-limb MSB.
REQ-029 Without ADD_SEQ_OVF_EN, the ovf port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-030 Package add_seq_pkg SHALL hold the state enum type (IDLE/RUN/DONE) and default DW/NW constants.
REQ-031 Sub-module limb_add SHALL implement the DW-bit add with carry-in, carry-out, and the MSB carry-in (for ovf); add_seq_ctrl SHALL instantiate it once.

Verification (DW=18, NW=4, 72-bit)
REQ-032 US=1, a=72'hFF_FFFF_FFFF_FFFF_FFFF, b=0, c_in=1 -> sum=0, carry=1, out_valid 4 cycles after accept.
REQ-033 US=0, a=b=all-ones (-1), c_in=0 -> sum=72'hFF_FFFF_FFFF_FFFF_FFFE, carry=1; with ADD_SEQ_OVF_EN, ovf=0.
REQ-034 US=0, ADD_SEQ_OVF_EN, a=72'h7F_FFFF_FFFF_FFFF_FFFF, b=1 -> sum=72'h80_0000_0000_0000_0000, carry=0, ovf=1.
REQ-035 out_ready held low 5 cycles in DONE -> out_valid, sum and carry stable; in_valid pulses ignored; in_ready=0 throughout.
REQ-036 rst asserted in the 2nd RUN cycle -> next cycle IDLE, out_valid=0, sum=0; a new operation afterwards completes correctly.
REQ-037 NW=1, US=1, a=18'h3FFFF, b=1, c_in=0 -> sum=0, carry=1, out_valid 1 cycle after accept.
